// File: rtl/pixel_clip_queue_pkg.sv
// Shared types and constants for the pixel clip queue and the drawing stages after it.
// The PLOT_DEDUP_EN build option lives in pixel_clip_queue.sv.
package pixel_clip_queue_pkg;

    localparam int unsigned VGA_W   = 160;
    localparam int unsigned VGA_H   = 120;
    localparam int unsigned IN_X_W  = 10;
    localparam int unsigned IN_Y_W  = 9;
    localparam int unsigned VGA_X_W = 8;
    localparam int unsigned VGA_Y_W = 7;
    localparam int unsigned COL_W   = 3;

    typedef enum logic [1:0] {
        PCQ_IDLE,
        PCQ_RUN,
        PCQ_DRAIN,
        PCQ_DONE
    } pcq_state_t;

    typedef struct packed {
        logic [VGA_X_W-1:0] x;
        logic [VGA_Y_W-1:0] y;
        logic [COL_W-1:0]   colour;
    } pixel_t;

    // Two's-complement coordinates: a clear sign bit plus an unsigned bound is the signed range test.
    function automatic logic on_screen(input logic [IN_X_W-1:0] x, input logic [IN_Y_W-1:0] y);
        return !x[IN_X_W-1] && (x < IN_X_W'(VGA_W)) &&
               !y[IN_Y_W-1] && (y < IN_Y_W'(VGA_H));
    endfunction

endpackage

// File: rtl/pixel_clip_queue_sync_fifo.sv
// Synchronous pixel FIFO with extra-bit pointers; reusable by the other drawing stages.
module pixel_clip_queue_sync_fifo
    import pixel_clip_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  pixel_t                   data_i,
    input  logic                     pop_i,
    output pixel_t                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    pixel_t        mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pixel_clip_queue.sv
// Clips raw signed octant pixels to the 160x120 grid, queues survivors for the VGA adapter
// and pulses done once the primitive is fully plotted. Option: PLOT_DEDUP_EN drops repeats.
module pixel_clip_queue
    import pixel_clip_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_X_W-1:0]   in_x,
    input  logic [IN_Y_W-1:0]   in_y,
    input  logic [COL_W-1:0]    in_colour,
    input  logic                in_last,
    input  logic                vga_ready,
    output logic [VGA_X_W-1:0]  vga_x,
    output logic [VGA_Y_W-1:0]  vga_y,
    output logic [COL_W-1:0]    vga_colour,
    output logic                vga_plot,
    output logic                done,
    output logic [CNT_W-1:0]    clip_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pcq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  clip_cnt_q, clip_cnt_d;
    logic              transfer;
    logic              start;
    logic              kept;
    logic              dup;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    pixel_t            pix_in;
    pixel_t            head;

    assign transfer = in_valid && in_ready;
    assign start    = transfer && ((state_q == PCQ_IDLE) || (state_q == PCQ_DONE));
    assign kept     = on_screen(in_x, in_y);
    assign pix_in   = '{x: VGA_X_W'(in_x), y: VGA_Y_W'(in_y), colour: in_colour};
    assign push     = transfer && kept && !dup;
    assign pop      = !fifo_empty && vga_ready;

`ifdef PLOT_DEDUP_EN
    pixel_t last_q, last_d;
    logic   last_vld_q, last_vld_d;

    // Compare register forgets the previous primitive as soon as the queue is idle.
    assign dup = last_vld_q && !start && (pix_in == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if ((state_q == PCQ_IDLE) || (state_q == PCQ_DONE)) last_vld_d = 1'b0;
        if (transfer && kept) begin
            last_d     = pix_in;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    pixel_clip_queue_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (pix_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PCQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PCQ_IDLE, PCQ_DONE: begin
                if (transfer)                  state_d = in_last ? PCQ_DRAIN : PCQ_RUN;
                else if (state_q == PCQ_DONE)  state_d = PCQ_IDLE;
            end
            PCQ_RUN: begin
                if (transfer && in_last) state_d = PCQ_DRAIN;
            end
            PCQ_DRAIN: begin
                // Empty already covers a primitive whose last pixel was clipped.
                if (fifo_empty || (pop && (fifo_count == CW'(1)))) state_d = PCQ_DONE;
            end
            default: state_d = PCQ_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !fifo_full && (state_q != PCQ_DRAIN);
        done       = (state_q == PCQ_DONE);
        vga_plot   = !fifo_empty;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (!fifo_empty) begin
            vga_x      = head.x;
            vga_y      = head.y;
            vga_colour = head.colour;
        end
    end

    // Dropped-pixel counter restarts with each primitive and sticks at all-ones.
    always_comb begin
        clip_cnt_d = start ? '0 : clip_cnt_q;
        if (transfer && !kept && (clip_cnt_d != '1)) clip_cnt_d = clip_cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip_cnt_q <= '0;
        else        clip_cnt_q <= clip_cnt_d;
    end

    assign clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_pixel_clip_queue.sv
// Scoreboard bench for pixel_clip_queue: clip model feeds an expected-pixel queue checked at plot time.
module tb_pixel_clip_queue;
    import pixel_clip_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [9:0]        in_x;
    logic [8:0]        in_y;
    logic [2:0]        in_colour;
    logic              in_last;
    logic              vga_ready;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              done;
    logic [CNT_W-1:0]  clip_cnt;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     plot_cnt = 0;
    int     done_cnt = 0;
    int     exp_clip = 0;
    pixel_t exp_q[$];
    pixel_t prev_pix;
    bit     prev_vld = 1'b0;
    pixel_t got_pix;
    pixel_t exp_pix;

    pixel_clip_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_last    (in_last),
        .vga_ready  (vga_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .done       (done),
        .clip_cnt   (clip_cnt)
    );

    always #5 clk = ~clk;

    // Every accepted plot is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vga_plot && vga_ready) begin
                got_pix = '{x: vga_x, y: vga_y, colour: vga_colour};
                n_tests++;
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL plot_unexpected: got (%0d,%0d,%0d), required no plot",
                             vga_x, vga_y, vga_colour);
                end else begin
                    exp_pix = exp_q.pop_front();
                    if (got_pix !== exp_pix) begin
                        n_fail++;
                        $display("FAIL plot_pixel: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                                 vga_x, vga_y, vga_colour, exp_pix.x, exp_pix.y, exp_pix.colour);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic begin_prim();
        exp_clip = 0;
        prev_vld = 1'b0;
    endtask

    task automatic push_pix(input int x, input int y, input int c, input bit last);
        pixel_t p;
        bit     kept;
        bit     dup;
        int     waitc;
        in_x      = 10'(x);
        in_y      = 9'(y);
        in_colour = 3'(c);
        in_last   = last;
        in_valid  = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=0 after %0d cycles, required 1", waitc);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        kept = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
        if (kept) begin
            p = '{x: 8'(x), y: 7'(y), colour: 3'(c)};
            dup = 1'b0;
`ifdef PLOT_DEDUP_EN
            dup = prev_vld && (p == prev_pix);
`endif
            if (!dup) exp_q.push_back(p);
            prev_pix = p;
            prev_vld = 1'b1;
        end else begin
            exp_clip++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, k);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int d0;
        vga_ready = 1'b0;
        begin_prim();
        for (int i = 0; i < 5; i++) push_pix(i * 3, i * 2, i, 1'b0);
        push_pix(-3, 4, 1, 1'b0);
        n_tests++;
        if (clip_cnt !== CNT_W'(exp_clip)) begin
            n_fail++;
            $display("FAIL reset_pre_clip: got %0d, required %0d", clip_cnt, exp_clip);
        end
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vga_plot, done, in_ready} !== 3'b001 || clip_cnt !== '0 || vga_x !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: plot=%0b done=%0b in_ready=%0b clip=%0d x=%0d, required 0 0 1 0 0",
                     vga_plot, done, in_ready, clip_cnt, vga_x);
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        vga_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (vga_plot !== 1'b0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_flush: plot=%0b done_pulses=%0d, required 0 0", vga_plot, done_cnt - d0);
        end
    endtask

    task automatic test_single();
        int d0;
        vga_ready = 1'b1;
        begin_prim();
        d0 = done_cnt;
        push_pix(10, 20, 3, 1'b1);
        n_tests++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20 || vga_colour !== 3'd3) begin
            n_fail++;
            $display("FAIL single_latency: plot=%0b (%0d,%0d,%0d), required 1 (10,20,3)",
                     vga_plot, vga_x, vga_y, vga_colour);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%0b plot=%0b, required 1 0", done, vga_plot);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || in_ready !== 1'b1 || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL single_pulse: done=%0b in_ready=%0b pulses=%0d, required 0 1 1",
                     done, in_ready, done_cnt - d0);
        end
    endtask

    task automatic test_clip();
        int d0, p0;
        vga_ready = 1'b1;
        begin_prim();
        d0 = done_cnt;
        p0 = plot_cnt;
        push_pix(-1, 5, 5, 1'b0);
        push_pix(160, 5, 5, 1'b0);
        push_pix(5, 120, 5, 1'b0);
        push_pix(0, 0, 5, 1'b0);
        push_pix(159, 119, 5, 1'b1);
        wait_done("clip");
        n_tests++;
        if (clip_cnt !== CNT_W'(exp_clip) || exp_clip != 3) begin
            n_fail++;
            $display("FAIL clip_count: got %0d, required 3", clip_cnt);
        end
        n_tests++;
        if (plot_cnt - p0 != 2 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL clip_plots: plots=%0d dones=%0d, required 2 1", plot_cnt - p0, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [7:0] held_x;
        vga_ready = 1'b0;
        begin_prim();
        p0 = plot_cnt;
        for (int i = 0; i < DEPTH; i++) push_pix(i + 1, i + 2, i % 8, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_in_ready: got %0b, required 0", in_ready);
        end
        held_x = vga_x;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (vga_x !== 8'd1 || held_x !== 8'd1 || vga_plot !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: x=%0d (was %0d) plot=%0b, required 1 1 1", vga_x, held_x, vga_plot);
        end
        fork
            begin
                repeat (3) @(posedge clk);
                #1 vga_ready = 1'b1;
            end
            begin
                push_pix(DEPTH + 1, DEPTH + 2, 6, 1'b0);
                push_pix(DEPTH + 2, DEPTH + 3, 7, 1'b1);
            end
        join
        wait_done("b2b");
        n_tests++;
        if (plot_cnt - p0 != DEPTH + 2) begin
            n_fail++;
            $display("FAIL b2b_plots: got %0d, required %0d", plot_cnt - p0, DEPTH + 2);
        end
    endtask

    task automatic test_all_clipped();
        int xs[$];
        int ys[$];
        int x, y, d, d0, p0;
        vga_ready = 1'b1;
        begin_prim();
        x = 10; y = 0; d = 1 - 10;
        while (x >= y) begin
            xs.push_back(200 + x); ys.push_back(125 + y);
            xs.push_back(200 + y); ys.push_back(125 + x);
            xs.push_back(200 - y); ys.push_back(125 + x);
            xs.push_back(200 - x); ys.push_back(125 + y);
            xs.push_back(200 - x); ys.push_back(125 - y);
            xs.push_back(200 - y); ys.push_back(125 - x);
            xs.push_back(200 + y); ys.push_back(125 - x);
            xs.push_back(200 + x); ys.push_back(125 - y);
            y++;
            if (d < 0) d += 2 * y + 1;
            else begin
                x--;
                d += 2 * (y - x) + 1;
            end
        end
        d0 = done_cnt;
        p0 = plot_cnt;
        foreach (xs[i]) push_pix(xs[i], ys[i], 2, i == xs.size() - 1);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL offscreen_early_done: got %0b, required 0", done);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL offscreen_done_timing: got %0b, required 1", done);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (clip_cnt !== CNT_W'(xs.size()) || plot_cnt != p0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL offscreen_summary: clip=%0d plots=%0d dones=%0d, required %0d 0 1",
                     clip_cnt, plot_cnt - p0, done_cnt - d0, xs.size());
        end
    endtask

    task automatic test_dedup();
        int p0, want;
        vga_ready = 1'b1;
        begin_prim();
        p0 = plot_cnt;
`ifdef PLOT_DEDUP_EN
        want = 2;
`else
        want = 3;
`endif
        push_pix(7, 7, 1, 1'b0);
        push_pix(7, 7, 1, 1'b0);
        push_pix(8, 7, 1, 1'b1);
        wait_done("dedup");
        n_tests++;
        if (plot_cnt - p0 != want || clip_cnt !== '0) begin
            n_fail++;
            $display("FAIL dedup_plots: plots=%0d clip=%0d, required %0d 0", plot_cnt - p0, clip_cnt, want);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        in_last   = 1'b0;
        vga_ready = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_clip();
        test_back_to_back();
        test_all_clipped();
        test_dedup();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d pixels never plotted, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
